// File: rtl/fb_scanout_if.sv
// Framebuffer read port plus VGA pin bundle for the scanout block.
// master: the scanout engine; slave: framebuffer memory and display side.
interface fb_scanout_if;
    logic [18:0] rd_addr;
    logic [11:0] rd_data;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        vblank;
    logic        frame_start;

    modport master (
        output rd_addr,
        input  rd_data,
        output hsync,
        output vsync,
        output red,
        output green,
        output blue,
        output vblank,
        output frame_start
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  hsync,
        input  vsync,
        input  red,
        input  green,
        input  blue,
        input  vblank,
        input  frame_start
    );
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scanout: VGA timing counters, one linear read per visible
// pixel, and a sync/visibility delay line matched to the read latency so
// pixel data reaches the pins in phase with hsync/vsync.
module fb_scanout #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    fb_scanout_if.master  bus
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
    localparam int unsigned DEPTH    = RD_LATENCY + 1;
    localparam int          HW       = $clog2(H_TOTAL);
    localparam int          VW       = $clog2(V_TOTAL);

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [18:0]      pix_addr;
    logic             vis;
    logic             hs_n;
    logic             vs_n;
    logic [DEPTH-1:0] vis_pipe;
    logic [DEPTH-1:0] hs_pipe;
    logic [DEPTH-1:0] vs_pipe;

    // Counter-stage visibility and sync windows
    always_comb begin
        vis  = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
        hs_n = !((h_cnt >= HW'(HS_START)) && (h_cnt <= HW'(HS_END)));
        vs_n = !((v_cnt >= VW'(VS_START)) && (v_cnt <= VW'(VS_END)));
    end

    // Raster counters and linear pixel address (increments per visible pixel, no multiply)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            pix_addr <= '0;
        end else begin
            if (h_cnt == HW'(H_TOTAL - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            if (vis) begin
                pix_addr <= (pix_addr == 19'(H_VISIBLE * V_VISIBLE - 1)) ? '0 : pix_addr + 1'b1;
            end
        end
    end

    // Read address (held through blanking), vblank and frame_start, all undelayed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_addr     <= '0;
            bus.vblank      <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            if (vis) begin
                bus.rd_addr <= pix_addr;
            end
            bus.vblank      <= (v_cnt >= VW'(V_VISIBLE));
            bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // Delay line covering address register plus memory latency; reset fills it with blank/inactive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
        end else begin
            vis_pipe <= {vis_pipe[DEPTH-2:0], vis};
            hs_pipe  <= {hs_pipe[DEPTH-2:0], hs_n};
            vs_pipe  <= {vs_pipe[DEPTH-2:0], vs_n};
        end
    end

    // Pin register: gate read data with delayed visibility so blanking never passes rd_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.red   <= '0;
            bus.green <= '0;
            bus.blue  <= '0;
            bus.hsync <= 1'b1;
            bus.vsync <= 1'b1;
        end else begin
            {bus.red, bus.green, bus.blue} <= vis_pipe[DEPTH-1] ? bus.rd_data : 12'h000;
            bus.hsync <= hs_pipe[DEPTH-1];
            bus.vsync <= vs_pipe[DEPTH-1];
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: a full-size instance over its first
// lines and a reduced-geometry instance over several frames including a
// mid-frame reset, both compared every cycle against a position-based model.
module tb_fb_scanout;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
    } geom_t;

    typedef struct packed {
        int addr; int pix;
        bit hs; bit vs; bit vb; bit fs; bit vis;
    } exp_t;

    localparam geom_t GB = '{hv:640, hf:16, hs:96, hb:48, vv:480, vf:10, vs:2, vb:33};
    localparam geom_t GS = '{hv:8, hf:2, hs:3, hb:2, vv:6, vf:1, vs:2, vb:2};
    localparam int LAT   = 4;
    localparam int NPIX_S = GS.hv * GS.vv;
    localparam int NCYC  = 2600;

    logic clk = 1'b0;
    logic rst_b;
    logic rst_s;

    always #20 clk = ~clk;

    fb_scanout_if bus_b ();
    fb_scanout_if bus_s ();

    fb_scanout u_big (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    fb_scanout #(
        .H_VISIBLE (GS.hv), .H_FP (GS.hf), .H_SYNC (GS.hs), .H_BP (GS.hb),
        .V_VISIBLE (GS.vv), .V_FP (GS.vf), .V_SYNC (GS.vs), .V_BP (GS.vb),
        .RD_LATENCY (2)
    ) u_small (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s)
    );

    // Memory models with 2-clock latency: big returns low address bits, small a random image
    logic [11:0] mem_s [0:NPIX_S-1];
    logic [11:0] mb1, mb2, ms1, ms2;

    always @(posedge clk) begin
        mb1 <= bus_b.rd_addr[11:0];
        mb2 <= mb1;
        ms1 <= (int'(bus_s.rd_addr) < NPIX_S) ? mem_s[bus_s.rd_addr] : 12'hxxx;
        ms2 <= ms1;
    end
    assign bus_b.rd_data = mb2;
    assign bus_s.rd_data = ms2;

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Expected outputs k clocks after reset release, from raster position arithmetic
    function automatic exp_t model(input geom_t g, input int k);
        int ht, vt, s, h, v;
        exp_t e;
        ht = g.hv + g.hf + g.hs + g.hb;
        vt = g.vv + g.vf + g.vs + g.vb;
        e.addr = 0; e.pix = 0; e.hs = 1'b1; e.vs = 1'b1; e.vb = 1'b0; e.fs = 1'b0; e.vis = 1'b0;
        if (k >= 1) begin
            s = k - 1; h = s % ht; v = (s / ht) % vt;
            e.fs = (h == 0) && (v == 0);
            e.vb = (v >= g.vv);
            if (h < g.hv && v < g.vv) e.addr = v * g.hv + h;
            else if (v < g.vv)        e.addr = v * g.hv + g.hv - 1;
            else                      e.addr = g.hv * g.vv - 1;
        end
        if (k >= LAT) begin
            s = k - LAT; h = s % ht; v = (s / ht) % vt;
            e.vis = (h < g.hv) && (v < g.vv);
            e.pix = v * g.hv + h;
            e.hs  = !((h >= g.hv + g.hf) && (h < g.hv + g.hf + g.hs));
            e.vs  = !((v >= g.vv + g.vf) && (v < g.vv + g.vf + g.vs));
        end
        return e;
    endfunction

    task automatic check_dut(input string nm, input geom_t g, input int k, input bit use_mem,
                             input logic [18:0] addr, input logic [11:0] rgb, input logic hs,
                             input logic vs, input logic vb, input logic fs);
        exp_t e;
        logic [11:0] px;
        e = model(g, k);
        if (!e.vis)       px = 12'h000;
        else if (use_mem) px = mem_s[e.pix];
        else              px = 12'(e.pix);
        chk({nm, ".rd_addr"}, k, 32'(addr), 32'(e.addr));
        chk({nm, ".rgb"}, k, 32'(rgb), 32'(px));
        chk({nm, ".hsync"}, k, 32'(hs), 32'(e.hs));
        chk({nm, ".vsync"}, k, 32'(vs), 32'(e.vs));
        chk({nm, ".vblank"}, k, 32'(vb), 32'(e.vb));
        chk({nm, ".frame_start"}, k, 32'(fs), 32'(e.fs));
    endtask

    task automatic track(input string tag, input int k, input logic sig, input logic act,
                         inout int run, input int exp);
        if (sig === act) begin
            run++;
        end else begin
            if (run > 0) chk(tag, k, 32'(run), 32'(exp));
            run = 0;
        end
    endtask

    int kb, ks, hold, target, fs_last_s;
    int hs_run_b, hs_run_s, vs_run_s, vb_run_s;
    bit mid_done;

    initial begin
        n_chk = 0; n_fail = 0;
        for (int i = 0; i < NPIX_S; i++) mem_s[i] = 12'($urandom);
        rst_b = 1'b1; rst_s = 1'b1;
        kb = 0; ks = 0; hold = 0; fs_last_s = -1; mid_done = 1'b0;
        hs_run_b = 0; hs_run_s = 0; vs_run_s = 0; vb_run_s = 0;
        target = 165 + $urandom_range(30, 60);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_dut("big_reset", GB, 0, 1'b0, bus_b.rd_addr, {bus_b.red, bus_b.green, bus_b.blue},
                  bus_b.hsync, bus_b.vsync, bus_b.vblank, bus_b.frame_start);
        check_dut("small_reset", GS, 0, 1'b1, bus_s.rd_addr, {bus_s.red, bus_s.green, bus_s.blue},
                  bus_s.hsync, bus_s.vsync, bus_s.vblank, bus_s.frame_start);
        rst_b = 1'b0; rst_s = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            kb++;
            if (rst_s) hold++; else ks++;
            @(negedge clk);
            if (rst_s && hold == 3) begin
                rst_s = 1'b0; ks = 0; fs_last_s = -1;
                hs_run_s = 0; vs_run_s = 0; vb_run_s = 0;
            end

            check_dut("big", GB, kb, 1'b0, bus_b.rd_addr, {bus_b.red, bus_b.green, bus_b.blue},
                      bus_b.hsync, bus_b.vsync, bus_b.vblank, bus_b.frame_start);
            check_dut("small", GS, rst_s ? 0 : ks, 1'b1, bus_s.rd_addr,
                      {bus_s.red, bus_s.green, bus_s.blue},
                      bus_s.hsync, bus_s.vsync, bus_s.vblank, bus_s.frame_start);

            // Directed points on the full-size raster
            if (kb == 1)   chk("big_fs_first", kb, 32'(bus_b.frame_start), 32'd1);
            if (kb == 4)   chk("big_px_h0", kb, 32'({bus_b.red, bus_b.green, bus_b.blue}), 32'h000);
            if (kb == 5)   chk("big_px_h1", kb, 32'({bus_b.red, bus_b.green, bus_b.blue}), 32'h001);
            if (kb == 643) chk("big_px_h639", kb, 32'({bus_b.red, bus_b.green, bus_b.blue}), 32'h27F);
            if (kb == 640) chk("big_addr_639", kb, 32'(bus_b.rd_addr), 32'd639);
            if (kb == 800) chk("big_addr_hold", kb, 32'(bus_b.rd_addr), 32'd639);
            if (kb == 801) chk("big_addr_640", kb, 32'(bus_b.rd_addr), 32'd640);
            if (kb == 659) chk("big_hs_pre", kb, 32'(bus_b.hsync), 32'd1);
            if (kb == 660) chk("big_hs_fall", kb, 32'(bus_b.hsync), 32'd0);
            track("big_hs_low_len", kb, bus_b.hsync, 1'b0, hs_run_b, GB.hs);

            if (!rst_s) begin
                track("small_hs_low_len", ks, bus_s.hsync, 1'b0, hs_run_s, GS.hs);
                track("small_vs_low_len", ks, bus_s.vsync, 1'b0, vs_run_s, GS.vs * 15);
                track("small_vblank_len", ks, bus_s.vblank, 1'b1, vb_run_s, (GS.vf + GS.vs + GS.vb) * 15);
                if (bus_s.frame_start === 1'b1) begin
                    if (fs_last_s >= 0) chk("small_fs_period", ks, 32'(ks - fs_last_s), 32'd165);
                    fs_last_s = ks;
                end
            end

            if (!mid_done && ks == target) begin
                #5;
                rst_s = 1'b1; hold = 0; mid_done = 1'b1;
                #1;
                check_dut("small_midrst", GS, 0, 1'b1, bus_s.rd_addr,
                          {bus_s.red, bus_s.green, bus_s.blue},
                          bus_s.hsync, bus_s.vsync, bus_s.vblank, bus_s.frame_start);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Read side of the 640x480, 12-bit RGB444 framebuffer. The sprite and image writers fill that buffer.
- Generates standard 640x480@60 VGA timing on the pixel clock.
- Issues one framebuffer read per visible pixel and drives the pixel onto the VGA pins, aligned with the sync signals.
- Exports vblank and frame_start so writers can schedule updates outside the visible scan.

Parameters:
H_VISIBLE, 640, visible pixels per line (equals `WIDTH)
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, hsync pulse width, pixels
H_BP, 48, horizontal back porch, pixels
V_VISIBLE, 480, visible lines (equals `HEIGHT)
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vsync pulse width, lines
V_BP, 33, vertical back porch, lines
RD_LATENCY, 2, framebuffer read latency in clocks (address registered to data valid)

Ports:
clk  in  1  pixel clock (25 MHz); all logic on its rising edge
rst  in  1  asynchronous, active-high reset
rd_addr  out  19  framebuffer read address, registered
rd_data  in  12  framebuffer read data {R[11:8],G[7:4],B[3:0]}, valid RD_LATENCY clocks after rd_addr
hsync  out  1  horizontal sync, active low, registered
vsync  out  1  vertical sync, active low, registered
red  out  4  pixel red, registered
green  out  4  pixel green, registered
blue  out  4  pixel blue, registered
vblank  out  1  high while the scan counter is in lines >= V_VISIBLE, registered
frame_start  out  1  one-clock pulse at the start of each frame, registered

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, with H_TOTAL = 800.
  - v_cnt runs 0..V_TOTAL-1, with V_TOTAL = 525.
  - h_cnt increments every clock. At H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1.
- Visible region: vis = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- Address:
  - Linear pixel counter pix_addr is 0 at (0,0) and increments by 1 after each visible pixel.
  - Last visible pixel (639,479) has address 307199.
  - No multiplier is used.
  - rd_addr <= pix_addr on cycles where vis=1. It holds its value during blanking.
- Sync windows at counter stage:
  - hs_n = 0 for h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. [656,751].
  - vs_n = 0 for v_cnt in [490,491].
- Alignment pipeline:
  - vis, hs_n and vs_n are delayed through a shift register of depth RD_LATENCY+1.
  - Outputs are registered once more, so counter-to-pin latency is L = RD_LATENCY+2 clocks (4 at default).
  - At output: {red,green,blue} <= delayed_vis ? rd_data : 12'h000. hsync and vsync take the delayed hs_n and vs_n.
  - The pixel counted at (h,v) appears on the pins exactly L clocks later, in phase with its sync values.
- vblank: registered from (v_cnt >= V_VISIBLE), with no pipeline delay. It rises 1 clock after v_cnt becomes 480 and falls 1 clock after v_cnt wraps to 0.
- frame_start: high for exactly one clock, on the clock after the counters hold (0,0). This includes the first frame after reset.
- Reset (asynchronous assert, synchronous release):
  - Counters and pix_addr go to 0.
  - rd_addr = 0, hsync = vsync = 1, red/green/blue = 0, vblank = 0, frame_start = 0.
  - All delay-pipeline stages load vis=0, hs_n=1, vs_n=1.
  - For the first L clocks after release, outputs are blank with sync inactive. No partial pixel comes out of the pipeline.
- Reset mid-frame aborts the scan immediately. The next frame starts cleanly at (0,0) with pix_addr 0.
- rd_data is ignored whenever the delayed vis is 0; X on rd_data during blanking must not reach the pins.

Test Plan:
- Reset and first frame: hold rst high for 5 clocks, then release. Required:
  - rgb=0 and hsync=vsync=1 for the first 4 clocks.
  - frame_start=1 on clock 1 only.
  - rd_addr=0.
- Pixel alignment: model memory returns rd_addr[11:0] with 2-clock latency. Required: pixel (h,0) appears on rgb 4 clocks after h_cnt=h, for h=0,1,639, with values 0x000, 0x001 and 0x27F.
- Line boundary: at h_cnt=639 on v_cnt=0, rd_addr=639; the next visible read (h_cnt=0, v_cnt=1) gives rd_addr=640. rd_addr holds 639 through the 160 blank clocks.
- Sync windows:
  - hsync is low for exactly 96 clocks per line, falling 656+4 clocks after line start.
  - vsync is low for exactly 2×800 clocks, starting at line 490 plus 4 clocks.
- Frame wrap:
  - Last visible read is rd_addr=307199.
  - vblank is high for 45 lines (36000 clocks).
  - frame_start pulses every 420000 clocks.
  - First read of the next frame is rd_addr=0.
- Mid-frame reset: assert rst at v_cnt=200, h_cnt=300 for 3 clocks. Required:
  - Outputs go immediately to reset values.
  - After release, frame_start pulses, rd_addr restarts at 0, and rgb stays 0 for 4 clocks.
